instruction_fetch_unit: RTL

- Front-end stage directly upstream of the single-cycle datapath.
- Issues sequential word fetches to instruction memory over a request/grant plus in-order response handshake, and buffers returned {pc, instruction} pairs in a small queue.
- Presents the queue head to the datapath with valid/ready.
- On a redirect (jump, JR, taken branch) from the datapath PC logic: flushes the queue, discards in-flight responses, and restarts fetch at the new PC.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 86 ++++++++
 rtl/instruction_fetch_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared definitions for the instruction fetch front end.
//   - PC_W / WORD_BYTES : address width and instruction word size
//   - DEFAULT_RESET_PC  : default first fetch address
//   - fetch_entry_t     : {pc, instr} pair buffered between memory and datapath
//   - align_pc()        : clears the byte-offset bits of a PC
package fetch_pkg;

  localparam int unsigned     PC_W             = 32;
  localparam int unsigned     WORD_BYTES       = 4;
  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return pc & ~PC_W'(WORD_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
//   DEPTH-entry synchronous FIFO of fetch_entry_t. The head entry is read
//   straight out of the storage registers, so a push into an empty FIFO is
//   visible at the output on the following cycle.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     push        : write push_data (ignored when full and not popping)
//     push_data   : entry to write
//     pop         : drop head entry (ignored when empty)
//     flush       : discard all entries; overrides push and pop
//     head        : current head entry (storage contents, zero after reset)
//     empty       : no entries held
//     count       : number of entries held (0..DEPTH)
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t    mem_reg [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW:0]     count_reg;
  logic [DEPTH-1:0] wr_en;
  logic            do_push;
  logic            do_pop;

  assign do_pop  = pop && (count_reg != '0) && !flush;
  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign do_push = push && !flush && ((count_reg != (AW+1)'(DEPTH)) || do_pop);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = do_push && (wr_ptr_reg == AW'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) begin
          mem_reg[i] <= push_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign empty = (count_reg == '0);
  assign count = count_reg;

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Sequential instruction fetcher feeding the datapath. Word fetches are
//   issued over a request/grant interface with in-order responses; returned
//   {pc, instr} pairs are buffered in a DEPTH-entry queue and presented with
//   valid/ready. A redirect flushes the queue, marks every in-flight response
//   for discard and restarts fetching at the new PC.
//   Ports:
//     clk, rst_n       : clock, asynchronous active-low reset
//     mem_req/mem_addr : fetch request and word-aligned byte address
//     mem_gnt          : request accepted this cycle
//     mem_rvalid/rdata : in-order response
//     redirect_valid/pc: restart fetch stream at redirect_pc
//     instr_valid/ready: head-of-queue handshake to the datapath
//     instr_pc/data    : head PC and instruction word
//     fetch_misalign   : sticky flag for an unaligned redirect target
//                        (present only when FETCH_ALIGN_CHECK_EN is defined)
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [31:0]     mem_rdata,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [PC_W-1:0] instr_pc,
  output logic [31:0]     instr_data
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic            fetch_misalign
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [PC_W-1:0] fetch_pc_reg;
  logic [PC_W-1:0] resp_pc_reg;
  logic [CW-1:0]   outstanding_reg;
  logic [CW-1:0]   drop_cnt_reg;

  logic [CW-1:0]   occupancy;
  logic [CW:0]     credit_used;
  logic            fifo_empty;
  logic            grant;
  logic            rsp;
  logic            push;
  logic [PC_W-1:0] redirect_pc_aligned;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  assign redirect_pc_aligned = align_pc(redirect_pc);

  // Credit: every queued entry and every in-flight request (including ones
  // that will be dropped) holds a slot, so a returning response always fits.
  assign credit_used = {1'b0, occupancy} + {1'b0, outstanding_reg};
  assign mem_req     = rst_n && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
  assign mem_addr    = fetch_pc_reg;

  assign grant = mem_req && mem_gnt;
  // A response with nothing outstanding is a protocol violation and ignored.
  assign rsp   = mem_rvalid && (outstanding_reg != '0);
  // Responses arriving while a drop count is pending, or in a redirect
  // cycle, belong to the abandoned stream.
  assign push  = rsp && (drop_cnt_reg == '0) && !redirect_valid;

  assign push_entry = '{pc: resp_pc_reg, instr: mem_rdata};

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_entry),
    .pop      (instr_ready),
    .flush    (redirect_valid),
    .head     (head),
    .empty    (fifo_empty),
    .count    (occupancy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
    end else begin
      outstanding_reg <= outstanding_reg + CW'(grant) - CW'(rsp);
      if (redirect_valid) begin
        fetch_pc_reg <= redirect_pc_aligned;
        resp_pc_reg  <= redirect_pc_aligned;
        // Everything still in flight after this cycle is stale.
        drop_cnt_reg <= outstanding_reg - CW'(rsp);
      end else begin
        if (grant) begin
          fetch_pc_reg <= fetch_pc_reg + PC_W'(WORD_BYTES);
        end
        if (push) begin
          resp_pc_reg <= resp_pc_reg + PC_W'(WORD_BYTES);
        end
        if (rsp && (drop_cnt_reg != '0)) begin
          drop_cnt_reg <= drop_cnt_reg - CW'(1);
        end
      end
    end
  end

  assign instr_valid = !fifo_empty;
  assign instr_pc    = head.pc;
  assign instr_data  = head.instr;

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_misalign <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      fetch_misalign <= 1'b1;
    end
  end
`endif

`ifndef SYNTHESIS
  rvalid_needs_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n) mem_rvalid |-> (outstanding_reg != '0)
  );
`endif

endmodule
